id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS core, with integrated load-use hazard detection.
- Captures decoded control, operand data, immediate and register specifiers from ID.
- Presents them to EX, and to the forwarding unit as the ID_EX Rs/Rt/Rd fields.
- Inserts bubbles on load-use hazards and branch flushes; holds on an external stall.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_W, 5, register specifier width
- CNT_W, 16, bubble counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-low reset
- stall_i  in  1  external pipeline stall (memory not ready); freezes register
- flush_i  in  1  branch/jump taken in ID; squash instruction entering EX
- ID_valid_i  in  1  IF/ID holds a real instruction
- ID_WB_i  in  2  {RegWrite, MemtoReg}
- ID_M_i  in  2  {MemRead, MemWrite}
- ID_EX_i  in  4  {ALUSrc, ALUOp[1:0], RegDst}
- ID_rs_data_i  in  DATA_W  register file read data 1
- ID_rt_data_i  in  DATA_W  register file read data 2
- ID_imm_i  in  DATA_W  sign-extended immediate
- ID_rs_i  in  REG_W  inst[25:21]
- ID_rt_i  in  REG_W  inst[20:16]
- ID_rd_i  in  REG_W  inst[15:11]
- WB_o  out  2  registered WB control
- M_o  out  2  registered M control
- EX_o  out  4  registered EX control
- rs_data_o  out  DATA_W  registered data 1
- rt_data_o  out  DATA_W  registered data 2
- imm_o  out  DATA_W  registered immediate
- rs_o  out  REG_W  registered Rs (forwarding unit A compare)
- rt_o  out  REG_W  registered Rt (forwarding unit B compare)
- rd_o  out  REG_W  registered Rd
- valid_o  out  1  EX holds a real instruction
- hazard_o  out  1  combinational load-use hazard detected
- PC_write_o  out  1  combinational; 0 freezes PC
- IF_ID_write_o  out  1  combinational; 0 freezes IF/ID
- bubble_cnt_o  out  CNT_W  count of inserted bubbles

Behaviour:
- Reset (rst_i=0, async):
  - all registered outputs go to 0 immediately, including valid_o and bubble_cnt_o;
  - reset mid-operation discards the held instruction.
- hazard_o = valid_o & M_o[1] & (rt_o != 0) & ((rt_o == ID_rs_i) | (rt_o == ID_rt_i)) & ID_valid_i.
  - Uses the registered MemRead and Rt, i.e. a load currently in EX.
- PC_write_o = IF_ID_write_o = ~(hazard_o | stall_i).
- Per rising edge, in priority order:
  1. stall_i=1: hold every register, including valid_o; no bubble; counter unchanged.
  2. flush_i=1: load a bubble; counter +1.
  3. hazard_o=1: load a bubble; counter +1.
  4. Otherwise: load all ID inputs; valid_o <= ID_valid_i.
- Bubble contents:
  - WB_o, M_o, EX_o and valid_o = 0;
  - data, immediate and specifier fields = 0.
  - Rs/Rt/Rd = 0 prevents spurious forwarding matches.
- Latency: 1 cycle from ID inputs to outputs. A load-use pair costs exactly 1 bubble; on the next edge the load has left EX, hazard_o drops, and the dependent instruction loads.
- Flush and hazard together: a single bubble, counted once.
- bubble_cnt_o saturates at all-ones; no wrap.
- Control vector with ID_valid_i=0 in normal load: fields are still loaded, but valid_o=0 and WB_o, M_o are forced to 0.
- Load with rt=0: never triggers a hazard.

Test Plan:
- Reset: drive inputs nonzero, pulse rst_i=0 between edges -> all outputs 0 immediately, PC_write_o=1.
- Normal load: ID_WB_i=2'b10, ID_rs_i=3, ID_rt_i=4, ID_rd_i=5, ID_rs_data_i=32'h1234 -> next edge WB_o=2'b10, rs_o=3, rt_o=4, rd_o=5, rs_data_o=32'h1234, valid_o=1.
- Load-use:
  - stimulus: lw with rt=8 in EX (M_o=2'b10), ID instruction has rs=8;
  - hazard_o=1, PC_write_o=0, IF_ID_write_o=0;
  - next edge: bubble loaded (M_o=0, rt_o=0), bubble_cnt_o=1;
  - following edge: add loaded with rs_o=8.
- Load with rt=0 followed by consumer with rs=0 -> hazard_o=0, no bubble.
- Stall priority:
  - stall_i=1 while hazard_o=1 and flush_i=1 -> registers unchanged, counter unchanged, PC_write_o=0;
  - release stall -> one bubble, counter +1.
- Saturation: with CNT_W=2, apply 5 consecutive flushes -> bubble_cnt_o reaches 3 and stays 3.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register for the 5-stage MIPS core.
// It also detects load-use hazards and inserts bubbles for hazards and branch flushes.
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              ID_valid_i,
    input  logic [1:0]        ID_WB_i,
    input  logic [1:0]        ID_M_i,
    input  logic [3:0]        ID_EX_i,
    input  logic [DATA_W-1:0] ID_rs_data_i,
    input  logic [DATA_W-1:0] ID_rt_data_i,
    input  logic [DATA_W-1:0] ID_imm_i,
    input  logic [REG_W-1:0]  ID_rs_i,
    input  logic [REG_W-1:0]  ID_rt_i,
    input  logic [REG_W-1:0]  ID_rd_i,
    output logic [1:0]        WB_o,
    output logic [1:0]        M_o,
    output logic [3:0]        EX_o,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [REG_W-1:0]  rs_o,
    output logic [REG_W-1:0]  rt_o,
    output logic [REG_W-1:0]  rd_o,
    output logic              valid_o,
    output logic              hazard_o,
    output logic              PC_write_o,
    output logic              IF_ID_write_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic [1:0]        r_wb;
    logic [1:0]        r_m;
    logic [3:0]        r_ex;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic              r_valid;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic w_rt_nonzero;
    logic w_rt_match;
    logic w_hazard;
    logic w_bubble;
    logic w_cnt_full;

    // A load in EX (registered MemRead) whose target feeds the instruction now in ID.
    assign w_rt_nonzero = (r_rt != '0);
    assign w_rt_match   = (r_rt == ID_rs_i) || (r_rt == ID_rt_i);
    assign w_hazard     = r_valid & r_m[1] & w_rt_nonzero & w_rt_match & ID_valid_i;
    assign w_bubble     = flush_i | w_hazard;
    assign w_cnt_full   = (r_bubble_cnt == '1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wb         <= '0;
            r_m          <= '0;
            r_ex         <= '0;
            r_rs_data    <= '0;
            r_rt_data    <= '0;
            r_imm        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_valid      <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (!stall_i) begin
            if (w_bubble) begin
                // An all-zero bubble also clears Rs/Rt/Rd so forwarding cannot match it.
                r_wb      <= '0;
                r_m       <= '0;
                r_ex      <= '0;
                r_rs_data <= '0;
                r_rt_data <= '0;
                r_imm     <= '0;
                r_rs      <= '0;
                r_rt      <= '0;
                r_rd      <= '0;
                r_valid   <= 1'b0;
                if (!w_cnt_full) begin
                    r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
                end
            end else begin
                r_wb      <= ID_valid_i ? ID_WB_i : 2'b00;
                r_m       <= ID_valid_i ? ID_M_i  : 2'b00;
                r_ex      <= ID_EX_i;
                r_rs_data <= ID_rs_data_i;
                r_rt_data <= ID_rt_data_i;
                r_imm     <= ID_imm_i;
                r_rs      <= ID_rs_i;
                r_rt      <= ID_rt_i;
                r_rd      <= ID_rd_i;
                r_valid   <= ID_valid_i;
            end
        end
    end

    assign WB_o          = r_wb;
    assign M_o           = r_m;
    assign EX_o          = r_ex;
    assign rs_data_o     = r_rs_data;
    assign rt_data_o     = r_rt_data;
    assign imm_o         = r_imm;
    assign rs_o          = r_rs;
    assign rt_o          = r_rt;
    assign rd_o          = r_rd;
    assign valid_o       = r_valid;
    assign bubble_cnt_o  = r_bubble_cnt;
    assign hazard_o      = w_hazard;
    assign PC_write_o    = ~(w_hazard | stall_i);
    assign IF_ID_write_o = ~(w_hazard | stall_i);

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg; a transaction-level model is checked every cycle.
// A second instance with a 2-bit counter exercises saturation.
module tb_id_ex_stage_reg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              stall_i, flush_i, ID_valid_i;
    logic [1:0]        ID_WB_i, ID_M_i;
    logic [3:0]        ID_EX_i;
    logic [DATA_W-1:0] ID_rs_data_i, ID_rt_data_i, ID_imm_i;
    logic [REG_W-1:0]  ID_rs_i, ID_rt_i, ID_rd_i;

    logic [1:0]        WB_o, M_o;
    logic [3:0]        EX_o;
    logic [DATA_W-1:0] rs_data_o, rt_data_o, imm_o;
    logic [REG_W-1:0]  rs_o, rt_o, rd_o;
    logic              valid_o, hazard_o, PC_write_o, IF_ID_write_o;
    logic [15:0]       bubble_cnt_o;

    logic [1:0]        s_WB_o, s_M_o;
    logic [3:0]        s_EX_o;
    logic [DATA_W-1:0] s_rs_data_o, s_rt_data_o, s_imm_o;
    logic [REG_W-1:0]  s_rs_o, s_rt_o, s_rd_o;
    logic              s_valid_o, s_hazard_o, s_PC_write_o, s_IF_ID_write_o;
    logic [1:0]        s_bubble_cnt_o;

    always #5 clk_i = ~clk_i;

    id_ex_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .ID_valid_i(ID_valid_i), .ID_WB_i(ID_WB_i), .ID_M_i(ID_M_i), .ID_EX_i(ID_EX_i),
        .ID_rs_data_i(ID_rs_data_i), .ID_rt_data_i(ID_rt_data_i), .ID_imm_i(ID_imm_i),
        .ID_rs_i(ID_rs_i), .ID_rt_i(ID_rt_i), .ID_rd_i(ID_rd_i),
        .WB_o(WB_o), .M_o(M_o), .EX_o(EX_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o),
        .imm_o(imm_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .valid_o(valid_o),
        .hazard_o(hazard_o), .PC_write_o(PC_write_o), .IF_ID_write_o(IF_ID_write_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    id_ex_stage_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .ID_valid_i(ID_valid_i), .ID_WB_i(ID_WB_i), .ID_M_i(ID_M_i), .ID_EX_i(ID_EX_i),
        .ID_rs_data_i(ID_rs_data_i), .ID_rt_data_i(ID_rt_data_i), .ID_imm_i(ID_imm_i),
        .ID_rs_i(ID_rs_i), .ID_rt_i(ID_rt_i), .ID_rd_i(ID_rd_i),
        .WB_o(s_WB_o), .M_o(s_M_o), .EX_o(s_EX_o), .rs_data_o(s_rs_data_o),
        .rt_data_o(s_rt_data_o), .imm_o(s_imm_o), .rs_o(s_rs_o), .rt_o(s_rt_o),
        .rd_o(s_rd_o), .valid_o(s_valid_o), .hazard_o(s_hazard_o),
        .PC_write_o(s_PC_write_o), .IF_ID_write_o(s_IF_ID_write_o),
        .bubble_cnt_o(s_bubble_cnt_o)
    );

    // Model: what instruction sits in EX, and how many bubbles have been inserted.
    typedef struct packed {
        logic              valid;
        logic [1:0]        wb;
        logic [1:0]        m;
        logic [3:0]        ex;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
    } ex_slot_t;

    ex_slot_t m_ex;
    int       m_bubbles;
    int       n_cmp  = 0;
    int       n_fail = 0;
    bit       chk_en = 1'b0;

    function automatic bit model_hazard();
        bit is_load   = m_ex.valid && m_ex.m[1];
        bit depends   = (m_ex.rt == ID_rs_i) || (m_ex.rt == ID_rt_i);
        return is_load && (m_ex.rt != 0) && depends && ID_valid_i;
    endfunction

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_ex      = '0;
            m_bubbles = 0;
        end else if (!stall_i) begin
            if (flush_i || model_hazard()) begin
                m_ex      = '0;
                m_bubbles = m_bubbles + 1;
            end else begin
                m_ex.valid   = ID_valid_i;
                m_ex.wb      = ID_valid_i ? ID_WB_i : 2'b00;
                m_ex.m       = ID_valid_i ? ID_M_i : 2'b00;
                m_ex.ex      = ID_EX_i;
                m_ex.rs_data = ID_rs_data_i;
                m_ex.rt_data = ID_rt_data_i;
                m_ex.imm     = ID_imm_i;
                m_ex.rs      = ID_rs_i;
                m_ex.rt      = ID_rt_i;
                m_ex.rd      = ID_rd_i;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("WB_o", WB_o, m_ex.wb);
            check("M_o", M_o, m_ex.m);
            check("EX_o", EX_o, m_ex.ex);
            check("rs_data_o", rs_data_o, m_ex.rs_data);
            check("rt_data_o", rt_data_o, m_ex.rt_data);
            check("imm_o", imm_o, m_ex.imm);
            check("rs_o", rs_o, m_ex.rs);
            check("rt_o", rt_o, m_ex.rt);
            check("rd_o", rd_o, m_ex.rd);
            check("valid_o", valid_o, m_ex.valid);
            check("hazard_o", hazard_o, model_hazard());
            check("PC_write_o", PC_write_o, !(model_hazard() || stall_i));
            check("IF_ID_write_o", IF_ID_write_o, !(model_hazard() || stall_i));
            check("bubble_cnt_o", bubble_cnt_o, (m_bubbles > 65535) ? 65535 : m_bubbles);
            check("sat_bubble_cnt_o", s_bubble_cnt_o, (m_bubbles > 3) ? 3 : m_bubbles);
            check("sat_rt_o", s_rt_o, m_ex.rt);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] wb, input logic [1:0] m,
                         input logic [3:0] ex, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm);
        ID_valid_i   = v;
        ID_WB_i      = wb;
        ID_M_i       = m;
        ID_EX_i      = ex;
        ID_rs_i      = rs;
        ID_rt_i      = rt;
        ID_rd_i      = rd;
        ID_rs_data_i = d1;
        ID_rt_data_i = d2;
        ID_imm_i     = imm;
    endtask

    initial begin
        rst_i   = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        drive(1'b0, 2'b00, 2'b00, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        rst_i  = 1'b1;
        chk_en = 1'b1;

        // Plain load of an ALU instruction.
        drive(1'b1, 2'b10, 2'b00, 4'b0001, 5'd3, 5'd4, 5'd5, 32'h1234, 32'h5678, 32'h9);
        tick();
        check("lit_WB_o", WB_o, 2'b10);
        check("lit_rs_o", rs_o, 5'd3);
        check("lit_rt_o", rt_o, 5'd4);
        check("lit_rd_o", rd_o, 5'd5);
        check("lit_rs_data_o", rs_data_o, 32'h1234);
        check("lit_valid_o", valid_o, 1'b1);

        // Load-use: lw $8 followed by a consumer of $8.
        drive(1'b1, 2'b11, 2'b10, 4'b1000, 5'd2, 5'd8, 5'd0, 32'h100, 32'h0, 32'h10);
        tick();
        drive(1'b1, 2'b10, 2'b00, 4'b0011, 5'd8, 5'd9, 5'd10, 32'hAAAA, 32'hBBBB, 32'h0);
        #1;
        check("lit_hazard_o", hazard_o, 1'b1);
        check("lit_PC_write_o", PC_write_o, 1'b0);
        check("lit_IF_ID_write_o", IF_ID_write_o, 1'b0);
        tick();
        check("lit_bubble_M_o", M_o, 2'b00);
        check("lit_bubble_rt_o", rt_o, 5'd0);
        check("lit_bubble_cnt_1", bubble_cnt_o, 16'd1);
        check("lit_hazard_dropped", hazard_o, 1'b0);
        tick();
        check("lit_consumer_rs_o", rs_o, 5'd8);
        check("lit_consumer_valid", valid_o, 1'b1);

        // Load to $0 never stalls a consumer of $0.
        drive(1'b1, 2'b11, 2'b10, 4'b1000, 5'd1, 5'd0, 5'd0, 32'h200, 32'h0, 32'h4);
        tick();
        drive(1'b1, 2'b10, 2'b00, 4'b0011, 5'd0, 5'd0, 5'd11, 32'h0, 32'h0, 32'h0);
        #1;
        check("lit_rt0_hazard", hazard_o, 1'b0);
        tick();
        check("lit_rt0_no_bubble", bubble_cnt_o, 16'd1);
        check("lit_rt0_rd_o", rd_o, 5'd11);

        // Stall outranks both flush and hazard; releasing it yields one bubble.
        drive(1'b1, 2'b11, 2'b10, 4'b1000, 5'd1, 5'd7, 5'd0, 32'h300, 32'h0, 32'h8);
        tick();
        drive(1'b1, 2'b10, 2'b00, 4'b0011, 5'd7, 5'd2, 5'd12, 32'h0, 32'h0, 32'h0);
        flush_i = 1'b1;
        stall_i = 1'b1;
        #1;
        check("lit_stall_hazard", hazard_o, 1'b1);
        check("lit_stall_PC_write", PC_write_o, 1'b0);
        tick();
        check("lit_stall_rt_o", rt_o, 5'd7);
        check("lit_stall_M_o", M_o, 2'b10);
        check("lit_stall_cnt", bubble_cnt_o, 16'd1);
        stall_i = 1'b0;
        tick();
        check("lit_release_cnt", bubble_cnt_o, 16'd2);
        check("lit_release_valid", valid_o, 1'b0);
        flush_i = 1'b0;
        tick();
        check("lit_after_rd_o", rd_o, 5'd12);

        // Invalid slot: fields load but WB/M and valid are suppressed.
        drive(1'b0, 2'b11, 2'b11, 4'b1111, 5'd6, 5'd13, 5'd14, 32'hDEAD, 32'hBEEF, 32'h55);
        tick();
        check("lit_inv_valid", valid_o, 1'b0);
        check("lit_inv_WB_o", WB_o, 2'b00);
        check("lit_inv_M_o", M_o, 2'b00);
        check("lit_inv_EX_o", EX_o, 4'b1111);
        check("lit_inv_rs_o", rs_o, 5'd6);

        // Five flushes in a row: 16-bit counter keeps counting, 2-bit one pins at 3.
        drive(1'b1, 2'b10, 2'b00, 4'b0011, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
        flush_i = 1'b1;
        tick();
        check("lit_sat_first", s_bubble_cnt_o, 2'd3);
        for (int i = 0; i < 4; i++) tick();
        flush_i = 1'b0;
        check("lit_sat_hold", s_bubble_cnt_o, 2'd3);
        check("lit_wide_cnt", bubble_cnt_o, 16'd7);
        tick();
        check("lit_post_flush_valid", valid_o, 1'b1);

        // Asynchronous reset mid-cycle discards the held instruction.
        drive(1'b1, 2'b11, 2'b10, 4'b1000, 5'd4, 5'd9, 5'd0, 32'hFFFF, 32'hEEEE, 32'h1);
        tick();
        ID_rs_i = 5'd9;
        #2;
        rst_i = 1'b0;
        #1;
        check("lit_rst_valid", valid_o, 1'b0);
        check("lit_rst_rs_data", rs_data_o, 32'h0);
        check("lit_rst_rt_o", rt_o, 5'd0);
        check("lit_rst_cnt", bubble_cnt_o, 16'd0);
        check("lit_rst_PC_write", PC_write_o, 1'b1);
        tick();
        rst_i = 1'b1;
        tick();
        tick();
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
